// File: rtl/digit_entry_buffer_pkg.sv
// digit_entry_buffer_pkg: shared constants, types and helpers for the digit entry buffer.
//   DIGIT_W   - width of one hex digit
//   DEPTH     - number of digits in the store
//   ADDR_W    - width of the read address
//   CNT_W     - width of the valid-digit counter (holds 0..DEPTH)
//   deb_state_e - debouncer state encoding
package digit_entry_buffer_pkg;

    localparam int DIGIT_W = 4;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    // Count up by one but never past DEPTH; a push into a full store keeps the count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(DEPTH)) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/digit_entry_buffer_if.sv
// digit_entry_buffer_if: user/scan-side signal bundle of the digit entry buffer.
//   sw          - hex digit value to enter
//   btn_push    - raw PUSH button, active high, asynchronous
//   btn_clr     - raw CLEAR button, active high, asynchronous
//   rd_addr     - digit index from the scan counter
//   rd_data     - store content at rd_addr, combinational
//   digit_count - number of valid digits, 0..DEPTH
//   full        - high when digit_count == DEPTH
//   master: drives buttons/switches/address; slave: the buffer itself
interface digit_entry_buffer_if;
    import digit_entry_buffer_pkg::*;

    digit_t            sw;
    logic              btn_push;
    logic              btn_clr;
    logic [ADDR_W-1:0] rd_addr;
    digit_t            rd_data;
    logic [CNT_W-1:0]  digit_count;
    logic              full;

    modport master (
        output sw, btn_push, btn_clr, rd_addr,
        input  rd_data, digit_count, full
    );

    modport slave (
        input  sw, btn_push, btn_clr, rd_addr,
        output rd_data, digit_count, full
    );

endinterface

// File: rtl/digit_entry_buffer_key_debounce.sv
// key_debounce: tick-sampled debouncer turning a synchronized button into one press pulse.
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   tick_i   - sample strobe, one clk cycle wide
//   btn_s_i  - synchronized button level, active high
//   press_o  - one-cycle pulse when a press has been stable for STABLE_SAMPLES ticks
module key_debounce
    import digit_entry_buffer_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic btn_s_i,
    output logic press_o
);

    localparam int CW = $clog2(STABLE_SAMPLES + 1);

    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          last_sample;

    assign cnt_inc     = cnt_q + CW'(1);
    // True when the sample being taken now completes a stable run.
    assign last_sample = (cnt_inc == CW'(STABLE_SAMPLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // With STABLE_SAMPLES == 1 the wait states are skipped: the first
    // sample that differs already decides the edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        if (tick_i) begin
            case (state_q)
                IDLE: begin
                    if (btn_s_i) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d = HELD;
                            press_o = 1'b1;
                        end else begin
                            state_d = PRESS_WAIT;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s_i) begin
                        state_d = IDLE;
                    end else if (last_sample) begin
                        state_d = HELD;
                        press_o = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (!btn_s_i) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to 1 returns to HELD without a new press.
                    if (btn_s_i) begin
                        state_d = HELD;
                    end else if (last_sample) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: writable 8x4 digit store fed by debounced PUSH/CLEAR buttons.
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of digit_entry_buffer_if: sw, btn_push, btn_clr, rd_addr in;
//            rd_data (combinational mem[rd_addr]), digit_count, full out
// PUSH shifts sw in as digit 0 and moves the others up; CLEAR empties the store.
module digit_entry_buffer
    import digit_entry_buffer_pkg::*;
#(
    parameter int DEB_CYCLES     = 100_000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_entry_buffer_if.slave  bus
);

    localparam int TW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             tick;
    logic [1:0]       push_sync_q, clr_sync_q;
    logic             push_ev, clr_ev;
    digit_t           mem_q [DEPTH];
    digit_t           mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;

    assign tick   = (tcnt_q == TW'(DEB_CYCLES - 1));
    assign tcnt_d = tick ? '0 : tcnt_q + TW'(1);

    key_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_push_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_i  (tick),
        .btn_s_i (push_sync_q[1]),
        .press_o (push_ev)
    );

    key_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_clr_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_i  (tick),
        .btn_s_i (clr_sync_q[1]),
        .press_o (clr_ev)
    );

    // Clear takes priority so a simultaneous push is dropped rather than
    // leaving a stray digit behind.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clr_ev) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            count_d = '0;
        end else if (push_ev) begin
            for (int i = DEPTH - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
            mem_d[0] = bus.sw;
            count_d  = sat_inc(count_q);
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q      <= '0;
            push_sync_q <= '0;
            clr_sync_q  <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            tcnt_q      <= tcnt_d;
            push_sync_q <= {push_sync_q[0], bus.btn_push};
            clr_sync_q  <= {clr_sync_q[0], bus.btn_clr};
            count_q     <= count_d;
            full_q      <= full_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.rd_data     = mem_q[bus.rd_addr];
    assign bus.digit_count = count_q;
    assign bus.full        = full_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// tb_digit_entry_buffer: self-checking bench for digit_entry_buffer (DEB_CYCLES=4, STABLE_SAMPLES=3).
module tb_digit_entry_buffer;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;
    int   ecnt;

    digit_entry_buffer_if bus();

    digit_entry_buffer #(.DEB_CYCLES(4), .STABLE_SAMPLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int edge_n;
        int cnt;
        int full;
        int d0;
    } exp_t;

    typedef struct {
        logic [3:0] sw;
        int         cnt;
        int         full;
    } vec_t;

    exp_t       q[$];
    logic [3:0] mm[8];
    int         mcnt;
    vec_t       tbl[9];
    int         last_sig;
    int         cur_sig;
    exp_t       got;

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Edges since the last reset release; edge 1 is the first rising edge after release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else ecnt <= ecnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Scoreboard: any change of {digit_count, digit 0} is one buffer event.
    initial last_sig = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_sig = 0;
        end else begin
            cur_sig = {bus.digit_count, bus.rd_data};
            if (cur_sig != last_sig) begin
                last_sig = cur_sig;
                if (q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    got = q.pop_front();
                    chk("event_edge", ecnt, got.edge_n);
                    chk("event_count", bus.digit_count, got.cnt);
                    chk("event_full", bus.full, got.full);
                    chk("event_digit0", bus.rd_data, got.d0);
                end
            end
        end
    end

    task automatic model_push(input logic [3:0] v);
        for (int i = 7; i > 0; i--) mm[i] = mm[i-1];
        mm[0] = v;
        if (mcnt < 8) mcnt++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mm[i] = 4'h0;
        mcnt = 0;
    endtask

    // m is the rising edge at which the raw button is first seen high.
    task automatic expect_event(input int m);
        exp_t e;
        e.edge_n = ((m + 2 + 3) / 4) * 4 + 8;
        e.cnt    = mcnt;
        e.full   = (mcnt == 8) ? 1 : 0;
        e.d0     = mm[0];
        q.push_back(e);
    endtask

    task automatic sweep(input string nm);
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a);
            #1;
            chk($sformatf("%s_rd%0d", nm, a), bus.rd_data, mm[a]);
        end
        bus.rd_addr = 3'd0;
        chk({nm, "_count"}, bus.digit_count, mcnt);
        chk({nm, "_full"}, bus.full, (mcnt == 8) ? 1 : 0);
    endtask

    task automatic press_op(input bit p, input bit c, input int hold);
        @(negedge clk);
        if (c) model_clear();
        else model_push(bus.sw);
        expect_event(ecnt + 1);
        bus.btn_push = p;
        bus.btn_clr  = c;
        repeat (hold) @(negedge clk);
        bus.btn_push = 1'b0;
        bus.btn_clr  = 1'b0;
        repeat (20) @(negedge clk);
        chk("event_seen", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int m;
        int s2;
        int guard;
        tbl[0] = '{4'h1, 1, 0};
        tbl[1] = '{4'h2, 2, 0};
        tbl[2] = '{4'h3, 3, 0};
        tbl[3] = '{4'h4, 4, 0};
        tbl[4] = '{4'h5, 5, 0};
        tbl[5] = '{4'h6, 6, 0};
        tbl[6] = '{4'h7, 7, 0};
        tbl[7] = '{4'h8, 8, 1};
        tbl[8] = '{4'h9, 8, 1};
        checks = 0;
        fails  = 0;
        model_clear();
        rst_n        = 1'b1;
        bus.sw       = 4'h0;
        bus.btn_push = 1'b0;
        bus.btn_clr  = 1'b0;
        bus.rd_addr  = 3'd0;
        // Reset asserted mid-cycle must clear outputs before any clock edge.
        #3 rst_n = 1'b0;
        #1 sweep("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Clean press: one event, on the third sampling tick.
        bus.sw = 4'hA;
        press_op(1'b1, 1'b0, 20);
        sweep("first_push");
        // Bouncing press: only the settled level produces an event.
        bus.sw = 4'hB;
        @(negedge clk);
        bus.btn_push = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_push = 1'b0;
        repeat (4) @(negedge clk);
        bus.btn_push = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_push = 1'b0;
        repeat (4) @(negedge clk);
        press_op(1'b1, 1'b0, 20);
        sweep("bounce");
        bus.sw = 4'hC;
        press_op(1'b1, 1'b0, 20);
        // Push and clear landing together: clear wins.
        press_op(1'b1, 1'b1, 20);
        sweep("push_and_clear");
        // Nine presses: fills, then shifts the oldest digit out.
        for (int i = 0; i < 9; i++) begin
            bus.sw = tbl[i].sw;
            press_op(1'b1, 1'b0, 20);
            chk($sformatf("vec%0d_count", i), bus.digit_count, tbl[i].cnt);
            chk($sformatf("vec%0d_full", i), bus.full, tbl[i].full);
        end
        sweep("fill");
        bus.rd_addr = 3'd7;
        #1 chk("oldest_kept", bus.rd_data, 2);
        bus.rd_addr = 3'd0;
        // Reset in PRESS_WAIT with cnt=2, button kept held.
        bus.sw = 4'h5;
        @(negedge clk);
        m = ecnt + 1;
        bus.btn_push = 1'b1;
        s2 = ((m + 2 + 3) / 4) * 4 + 4;
        guard = 0;
        while (ecnt < s2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_cnt2", (ecnt == s2) ? 1 : 0, 1);
        #1 rst_n = 1'b0;
        model_clear();
        #1 sweep("mid_press_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_push(bus.sw);
        expect_event(ecnt + 1);
        repeat (20) @(negedge clk);
        bus.btn_push = 1'b0;
        repeat (20) @(negedge clk);
        chk("event_after_reset", q.size(), 0);
        sweep("after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
